fifo_pop_stream: RTL and testbench

Pop-side reader for the flopped single-push/single-pop FIFO. It drains the FIFO's head entry through `single_pop` and presents the entries downstream as a registered valid/ready stream. A 2-entry main+skid buffer sustains 1 entry/cycle without a combinational path from `m_ready` to `single_pop`. It sits between the FIFO and any consumer that applies backpressure.

---
 rtl/fifo_pop_stream.sv | 93 +++++++++
 tb/tb_fifo_pop_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_stream.sv
// Pop-side reader for a flopped single-push/single-pop FIFO. It drains the FIFO head
// into a main+skid pair and presents the entries as a registered valid/ready stream.
module fifo_pop_stream #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] fifo_outData,
    input  logic              fifo_empty,
    output logic              single_pop,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [1:0]        occupancy,
    output logic              idle
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic [DWIDTH-1:0] r_skid;
    logic              w_pop;
    logic              w_deq;

    // Pop decision never looks at m_ready, so the consumer has no path into the FIFO.
    assign w_pop      = rst_n & ~fifo_empty & ~flush & (r_state != ST_TWO);
    assign w_deq      = m_valid & m_ready;
    assign single_pop = w_pop;
    assign idle       = (occupancy == 2'd0) & fifo_empty;

    // m_data is the main register; r_skid holds the younger entry in ST_TWO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            m_valid   <= 1'b0;
            m_data    <= '0;
            r_skid    <= '0;
            occupancy <= 2'd0;
        end else if (flush) begin
            r_state   <= ST_EMPTY;
            m_valid   <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_pop) begin
                        r_state   <= ST_ONE;
                        m_data    <= fifo_outData;
                        m_valid   <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                ST_ONE: begin
                    if (w_pop && w_deq) begin
                        m_data <= fifo_outData;
                    end else if (w_pop) begin
                        r_state   <= ST_TWO;
                        r_skid    <= fifo_outData;
                        occupancy <= 2'd2;
                    end else if (w_deq) begin
                        r_state   <= ST_EMPTY;
                        m_valid   <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                ST_TWO: begin
                    if (w_deq) begin
                        r_state   <= ST_ONE;
                        m_data    <= r_skid;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    r_state   <= ST_EMPTY;
                    m_valid   <= 1'b0;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

`ifdef ASSERT_ON
    a_no_underflow: assert property (@(posedge clk) !(single_pop && fifo_empty));
    a_stable_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready && !flush) |=> $stable(m_data));
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Bench for fifo_pop_stream: a queue model of the FIFO source and of the entries held
// by the block, checked every cycle against the DUT outputs and the emitted stream.
module tb_fifo_pop_stream;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] fifo_outData;
    logic          fifo_empty;
    logic          single_pop;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    occupancy;
    logic          idle;

    fifo_pop_stream #(.DWIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_outData (fifo_outData),
        .fifo_empty   (fifo_empty),
        .single_pop   (single_pop),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .occupancy    (occupancy),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src[$];
    logic [DW-1:0] held[$];
    logic [DW-1:0] dut_log[$];
    logic [DW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            gap_pct = 0;
    logic          gap = 1'b0;
    logic          last_rst = 1'b1;

    function automatic void refresh();
        fifo_empty   = (src.size() == 0) || gap;
        fifo_outData = (src.size() != 0) ? src[0] : DW'($urandom);
    endfunction

    // One clock: check at the falling edge, advance the model, re-drive after the rising edge.
    task automatic step();
        logic exp_pop;
        logic deq;
        @(negedge clk);
        exp_pop = rst_n && !fifo_empty && !flush && (held.size() < 2);
        n_vec++;
        if (single_pop !== exp_pop) begin
            n_err++;
            $display("FAIL single_pop: got %b want %b at %0t", single_pop, exp_pop, $time);
        end
        n_vec++;
        if (m_valid !== (held.size() != 0)) begin
            n_err++;
            $display("FAIL m_valid: got %b want %b at %0t", m_valid, held.size() != 0, $time);
        end
        n_vec++;
        if (occupancy !== 2'(held.size())) begin
            n_err++;
            $display("FAIL occupancy: got %0d want %0d at %0t", occupancy, held.size(), $time);
        end
        if (held.size() != 0) begin
            n_vec++;
            if (m_data !== held[0]) begin
                n_err++;
                $display("FAIL m_data: got %h want %h at %0t", m_data, held[0], $time);
            end
        end else if (last_rst) begin
            n_vec++;
            if (m_data !== '0) begin
                n_err++;
                $display("FAIL m_data_reset: got %h want 0 at %0t", m_data, $time);
            end
        end
        if (rst_n) begin
            n_vec++;
            if (idle !== ((held.size() == 0) && fifo_empty)) begin
                n_err++;
                $display("FAIL idle: got %b want %b at %0t", idle,
                         (held.size() == 0) && fifo_empty, $time);
            end
        end
        deq = (held.size() != 0) && m_ready;
        if (rst_n && m_valid && m_ready) dut_log.push_back(m_data);
        last_rst = !rst_n;
        if (!rst_n || flush) begin
            held.delete();
        end else begin
            if (deq) void'(held.pop_front());
            if (exp_pop) held.push_back(src.pop_front());
        end
        @(posedge clk);
        #1;
        gap = ($urandom_range(99) < gap_pct);
        refresh();
    endtask

    task automatic drain_and_check(input string name);
        logic bad;
        m_ready = 1'b1;
        flush   = 1'b0;
        gap_pct = 0;
        for (int c = 0; c < 100 && (src.size() != 0 || held.size() != 0); c++) step();
        step();
        n_vec++;
        if (src.size() != 0 || held.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: src=%0d held=%0d want 0/0", name, src.size(), held.size());
        end
        bad = (dut_log.size() != exp_q.size());
        for (int i = 0; i < dut_log.size() && !bad; i++) bad = (dut_log[i] !== exp_q[i]);
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s_stream: got %0d entries want %0d (first got %h want %h)", name,
                     dut_log.size(), exp_q.size(),
                     (dut_log.size() != 0) ? dut_log[0] : '0,
                     (exp_q.size() != 0) ? exp_q[0] : '0);
        end
        dut_log.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        src = '{32'h55};
        refresh();
        rst_n = 1'b0;
        repeat (3) step();
        src.delete();
        rst_n = 1'b1;
        refresh();
        step();
        step();
        dut_log.delete();
    endtask

    task automatic test_streaming();
        m_ready = 1'b1;
        src = '{32'h11, 32'h22, 32'h33, 32'h44};
        refresh();
        exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        drain_and_check("streaming");
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        src = '{32'hA0, 32'hA1, 32'hA2};
        refresh();
        repeat (4) step();
        exp_q = '{32'hA0, 32'hA1, 32'hA2};
        drain_and_check("backpressure");
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        for (int i = 0; i < 16; i++) exp_q.push_back(DW'(i));
        refresh();
        for (int c = 0; c < 100 && (src.size() != 0 || held.size() != 0); c++) begin
            m_ready = c[0] ? 1'b0 : 1'b1;
            step();
        end
        drain_and_check("alternating");
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        src = '{32'hB0, 32'hB1};
        refresh();
        repeat (3) step();
        flush = 1'b1;
        refresh();
        step();
        flush = 1'b0;
        src.push_back(32'hC0);
        refresh();
        m_ready = 1'b1;
        exp_q = '{32'hC0};
        drain_and_check("flush");
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        src = '{32'hD0, 32'hD1, 32'hD2};
        refresh();
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        exp_q = '{32'hD2};
        drain_and_check("reset_mid");
    endtask

    task automatic test_random();
        logic [DW-1:0] v;
        gap_pct = 30;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(99) < 40) begin
                v = DW'($urandom);
                src.push_back(v);
            end
            m_ready = ($urandom_range(99) < 60);
            flush   = ($urandom_range(99) < 4);
            refresh();
            step();
        end
        flush = 1'b0;
        dut_log.delete();
        for (int i = 0; i < src.size(); i++) exp_q.push_back(src[i]);
        for (int i = 0; i < held.size(); i++) exp_q.push_front(held[held.size() - 1 - i]);
        drain_and_check("random");
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_alternating();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
